// File: rtl/two_byte_sort.sv
// Two-input compare-and-swap element: presents a registered pair in sorted order.
// Sort direction and signedness are fixed at elaboration.
module two_byte_sort #(
  parameter int WIDTH      = 8,
  parameter int DESCENDING = 0,
  parameter int SIGNED     = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] word1,
  input  logic [WIDTH-1:0] word2,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right
);

  function automatic logic is_greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    if (SIGNED != 0) return sa > sb;
    else             return a > b;
  endfunction

  logic             swap_p0;
  logic [WIDTH-1:0] left_p0;
  logic [WIDTH-1:0] right_p0;
  logic [WIDTH-1:0] left_p1;
  logic [WIDTH-1:0] right_p1;

  // Stage p0: combinational compare; ties never swap so equal words pass straight through
  always_comb begin
    swap_p0  = (DESCENDING != 0) ? is_greater(word2, word1) : is_greater(word1, word2);
    left_p0  = swap_p0 ? word2 : word1;
    right_p0 = swap_p0 ? word1 : word2;
  end

  // Stage p1: output register, cleared asynchronously so stale pairs never leak past reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      left_p1  <= '0;
      right_p1 <= '0;
    end else begin
      left_p1  <= left_p0;
      right_p1 <= right_p0;
    end
  end

  assign left  = left_p1;
  assign right = right_p1;

endmodule

// File: tb/tb_two_byte_sort.sv
// Directed bench for two_byte_sort: unsigned ascending, signed ascending and
// unsigned descending instances share the same stimulus.
module tb_two_byte_sort;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] word1 = 8'h00;
  logic [7:0] word2 = 8'h00;
  logic [7:0] left_u, right_u, left_s, right_s, left_d, right_d;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  two_byte_sort #(.WIDTH(8), .DESCENDING(0), .SIGNED(0)) dut_u (
    .clock(clock), .reset(reset), .word1(word1), .word2(word2), .left(left_u), .right(right_u));
  two_byte_sort #(.WIDTH(8), .DESCENDING(0), .SIGNED(1)) dut_s (
    .clock(clock), .reset(reset), .word1(word1), .word2(word2), .left(left_s), .right(right_s));
  two_byte_sort #(.WIDTH(8), .DESCENDING(1), .SIGNED(0)) dut_d (
    .clock(clock), .reset(reset), .word1(word1), .word2(word2), .left(left_d), .right(right_d));

  // Drive a pair at the falling edge, then sample one falling edge later (after one rising edge)
  task automatic apply(input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    word1 = a;
    word2 = b;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    word1 = 8'hAA;
    word2 = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total_cnt++; if (left_u !== 8'h00 || right_u !== 8'h00) $display("FAIL reset_hold_u cyc%0d got %h/%h want 00/00", i, left_u, right_u); else pass_cnt++;
      total_cnt++; if (left_s !== 8'h00 || right_s !== 8'h00) $display("FAIL reset_hold_s cyc%0d got %h/%h want 00/00", i, left_s, right_s); else pass_cnt++;
      total_cnt++; if (left_d !== 8'h00 || right_d !== 8'h00) $display("FAIL reset_hold_d cyc%0d got %h/%h want 00/00", i, left_d, right_d); else pass_cnt++;
    end
    reset = 1'b1;
    @(negedge clock);
    total_cnt++; if (left_u !== 8'h55 || right_u !== 8'hAA) $display("FAIL reset_release_u got %h/%h want 55/aa", left_u, right_u); else pass_cnt++;
  endtask

  task automatic test_ordered();
    apply(8'h12, 8'h34);
    total_cnt++; if (left_u !== 8'h12 || right_u !== 8'h34) $display("FAIL ordered_u got %h/%h want 12/34", left_u, right_u); else pass_cnt++;
    total_cnt++; if (left_s !== 8'h12 || right_s !== 8'h34) $display("FAIL ordered_s got %h/%h want 12/34", left_s, right_s); else pass_cnt++;
    total_cnt++; if (left_d !== 8'h34 || right_d !== 8'h12) $display("FAIL descending got %h/%h want 34/12", left_d, right_d); else pass_cnt++;
  endtask

  task automatic test_swapped();
    apply(8'hF0, 8'h0F);
    total_cnt++; if (left_u !== 8'h0F || right_u !== 8'hF0) $display("FAIL swapped_u got %h/%h want 0f/f0", left_u, right_u); else pass_cnt++;
    total_cnt++; if (left_s !== 8'hF0 || right_s !== 8'h0F) $display("FAIL swapped_s got %h/%h want f0/0f", left_s, right_s); else pass_cnt++;
    total_cnt++; if (left_d !== 8'hF0 || right_d !== 8'h0F) $display("FAIL swapped_d got %h/%h want f0/0f", left_d, right_d); else pass_cnt++;
  endtask

  task automatic test_extremes();
    apply(8'h7F, 8'h7F);
    total_cnt++; if (left_u !== 8'h7F || right_u !== 8'h7F) $display("FAIL tie_u got %h/%h want 7f/7f", left_u, right_u); else pass_cnt++;
    total_cnt++; if (left_d !== 8'h7F || right_d !== 8'h7F) $display("FAIL tie_d got %h/%h want 7f/7f", left_d, right_d); else pass_cnt++;
    apply(8'hFF, 8'h00);
    total_cnt++; if (left_u !== 8'h00 || right_u !== 8'hFF) $display("FAIL extreme_u got %h/%h want 00/ff", left_u, right_u); else pass_cnt++;
    total_cnt++; if (left_s !== 8'hFF || right_s !== 8'h00) $display("FAIL extreme_s got %h/%h want ff/00", left_s, right_s); else pass_cnt++;
    apply(8'h00, 8'hFF);
    total_cnt++; if (left_u !== 8'h00 || right_u !== 8'hFF) $display("FAIL extreme_rev_u got %h/%h want 00/ff", left_u, right_u); else pass_cnt++;
    total_cnt++; if (left_d !== 8'hFF || right_d !== 8'h00) $display("FAIL extreme_rev_d got %h/%h want ff/00", left_d, right_d); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] in1 [3] = '{8'h05, 8'h01, 8'h80};
    logic [7:0] in2 [3] = '{8'h03, 8'h09, 8'h80};
    logic [7:0] exl [3] = '{8'h03, 8'h01, 8'h80};
    logic [7:0] exr [3] = '{8'h05, 8'h09, 8'h80};
    @(negedge clock);
    word1 = in1[0];
    word2 = in2[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total_cnt++; if (left_u !== exl[i] || right_u !== exr[i]) $display("FAIL stream%0d got %h/%h want %h/%h", i, left_u, right_u, exl[i], exr[i]); else pass_cnt++;
      if (i < 2) begin
        word1 = in1[i+1];
        word2 = in2[i+1];
      end
    end
  endtask

  task automatic test_hold_between_edges();
    apply(8'h21, 8'h10);
    #2;
    word1 = 8'h00;
    word2 = 8'hEE;
    #1;
    total_cnt++; if (left_u !== 8'h10 || right_u !== 8'h21) $display("FAIL hold_between got %h/%h want 10/21", left_u, right_u); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    apply(8'h44, 8'h22);
    total_cnt++; if (left_u !== 8'h22 || right_u !== 8'h44) $display("FAIL pre_async got %h/%h want 22/44", left_u, right_u); else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    total_cnt++; if (left_u !== 8'h00 || right_u !== 8'h00) $display("FAIL async_clear_u got %h/%h want 00/00", left_u, right_u); else pass_cnt++;
    total_cnt++; if (left_d !== 8'h00 || right_d !== 8'h00) $display("FAIL async_clear_d got %h/%h want 00/00", left_d, right_d); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (left_u !== 8'h00 || right_u !== 8'h00) $display("FAIL async_hold got %h/%h want 00/00", left_u, right_u); else pass_cnt++;
    word1 = 8'h9A;
    word2 = 8'h3C;
    reset = 1'b1;
    #2;
    total_cnt++; if (left_u !== 8'h00 || right_u !== 8'h00) $display("FAIL post_release_pre_edge got %h/%h want 00/00", left_u, right_u); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (left_u !== 8'h3C || right_u !== 8'h9A) $display("FAIL first_capture got %h/%h want 3c/9a", left_u, right_u); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ordered();
    test_swapped();
    test_extremes();
    test_back_to_back();
    test_hold_between_edges();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
